adsb_modulator: RTL and testbench

ADS-B 1090ES test-signal transmitter, the transmit-side counterpart of the ADS-B demodulator. It accepts 112-bit Mode-S extended-squitter messages over AXI-stream and can optionally regenerate the 24-bit parity field. It emits a pulse-position-modulated baseband IQ stream (preamble plus 112 PPM bits) on a DAC sample strobe. It sits between the PS/DMA config path and the DAC/loopback input, so it can drive the demodulator in closed-loop tests.

---
 rtl/adsb_pkg.sv | 24 ++
 rtl/adsb_crc24_serial.sv | 39 +++
 rtl/adsb_modulator.sv | 244 ++++++++++++++++++++++++
 tb/tb_adsb_modulator.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adsb_pkg.sv
// Shared ADS-B 1090ES constants and the modulator state type.
package adsb_pkg;

   localparam int unsigned adsb_msg_bits       = 112;
   localparam int unsigned adsb_crc_bits       = 24;
   localparam int unsigned adsb_preamble_chips = 16;
   localparam logic [15:0] adsb_preamble       = 16'hA140;
   localparam logic [23:0] adsb_crc_poly       = 24'hFFF409;

   // Two chips per PPM bit; only the first 88 bits feed the parity generator.
   localparam int unsigned adsb_data_chips     = 2 * adsb_msg_bits;
   localparam int unsigned adsb_crc_data_chips = 2 * (adsb_msg_bits - adsb_crc_bits);

   typedef enum logic [2:0] {
      ST_IDLE        = 3'd0,
      ST_LOAD        = 3'd1,
      ST_WAIT_STROBE = 3'd2,
      ST_PREAMBLE    = 3'd3,
      ST_DATA        = 3'd4,
      ST_GAP         = 3'd5,
      ST_DRAIN       = 3'd6
   } adsb_mod_state_t;

endpackage

// File: rtl/adsb_crc24_serial.sv
// Bit-serial Mode-S CRC-24 (init 0), one message bit per enabled cycle.
module adsb_crc24_serial
   import adsb_pkg::*;
(
   input  logic        clk,
   input  logic        resetn,
   input  logic        clr,
   input  logic        bit_en,
   input  logic        data_bit,
   output logic [23:0] remainder
);

   logic [23:0] rem_q;
   logic [23:0] rem_d;
   logic        fb;

   // Next remainder: shift with feedback of the incoming bit against the MSB.
   always_comb begin
      rem_d = rem_q;
      fb    = data_bit ^ rem_q[23];
      if (clr) begin
         rem_d = '0;
      end else if (bit_en) begin
         rem_d = {rem_q[22:0], 1'b0} ^ (fb ? adsb_crc_poly : 24'h000000);
      end
   end

   // Remainder register.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         rem_q <= '0;
      end else begin
         rem_q <= rem_d;
      end
   end

   assign remainder = rem_q;

endmodule

// File: rtl/adsb_modulator.sv
// ADS-B 1090ES PPM test-signal transmitter: AXI-stream message in, DAC IQ samples out.
module adsb_modulator
   import adsb_pkg::*;
#(
   parameter int unsigned AXI_DATA_WIDTH   = 32,
   parameter int unsigned IQ_WIDTH         = 14,
   parameter int unsigned SAMPLE_DIV       = 16,
   parameter int unsigned SAMPLES_PER_CHIP = 2,
   parameter int unsigned GAP_CHIPS        = 16,
   parameter int unsigned AMPLITUDE        = 4096
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       s_axis_valid,
   output logic                       s_axis_ready,
   input  logic [AXI_DATA_WIDTH-1:0]  s_axis_data,
   input  logic                       s_axis_last,
   output logic                       dac_valid,
   output logic signed [IQ_WIDTH-1:0] dac_data_i,
   output logic signed [IQ_WIDTH-1:0] dac_data_q,
   output logic                       busy,
   output logic                       tx_done,
   output logic                       frame_err
);

   localparam int unsigned DIV_W    = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam int unsigned SUB_W    = $clog2(SAMPLES_PER_CHIP + 1);
   localparam int unsigned CHIP_MAX = (GAP_CHIPS > adsb_data_chips) ? GAP_CHIPS : adsb_data_chips;
   localparam int unsigned CHIP_W   = $clog2(CHIP_MAX + 1);
   localparam int unsigned MSG_W    = adsb_msg_bits;

   adsb_mod_state_t             state_q, state_d;
   logic [DIV_W-1:0]            cnt_q, cnt_d;
   logic [1:0]                  word_cnt_q, word_cnt_d;
   logic [MSG_W-1:0]            msg_q, msg_d;
   logic                        crc_en_q, crc_en_d;
   logic [CHIP_W-1:0]           chip_q, chip_d;
   logic [SUB_W-1:0]            sub_q, sub_d;
   logic                        gap_done_q, gap_done_d;
   logic                        ready_q, ready_d;
   logic                        dac_valid_q, dac_valid_d;
   logic signed [IQ_WIDTH-1:0]  dac_i_q, dac_i_d;
   logic                        busy_q, busy_d;
   logic                        tx_done_q, tx_done_d;
   logic                        frame_err_q, frame_err_d;

   logic                        strobe_c;
   logic                        accept_c;
   logic                        sub_end_c;
   logic                        chip_on_c;
   logic [3:0]                  pre_idx_c;
   logic                        crc_clr_c;
   logic                        crc_bit_en_c;
   logic [23:0]                 crc_rem;
   logic                        unused_word3_bits;

   // Header bits of word3 other than CRC_EN carry no meaning.
   assign unused_word3_bits = ^s_axis_data[15:1];

   adsb_crc24_serial u_crc (
      .clk       (clk),
      .resetn    (resetn),
      .clr       (crc_clr_c),
      .bit_en    (crc_bit_en_c),
      .data_bit  (msg_q[MSG_W-1]),
      .remainder (crc_rem)
   );

   // Next-state, buffer, sequencing and output computation.
   always_comb begin
      state_d      = state_q;
      word_cnt_d   = word_cnt_q;
      msg_d        = msg_q;
      crc_en_d     = crc_en_q;
      chip_d       = chip_q;
      sub_d        = sub_q;
      gap_done_d   = gap_done_q;
      dac_i_d      = dac_i_q;
      busy_d       = busy_q;
      tx_done_d    = 1'b0;
      frame_err_d  = 1'b0;
      crc_clr_c    = 1'b0;
      crc_bit_en_c = 1'b0;
      chip_on_c    = 1'b0;
      pre_idx_c    = 4'(adsb_preamble_chips - 1) - chip_q[3:0];

      cnt_d       = (cnt_q == DIV_W'(SAMPLE_DIV - 1)) ? '0 : cnt_q + DIV_W'(1);
      strobe_c    = (cnt_d == '0);
      dac_valid_d = strobe_c;
      accept_c    = s_axis_valid & ready_q;
      sub_end_c   = (sub_q == SUB_W'(SAMPLES_PER_CHIP - 1));

      // Every strobe outputs zero unless a pulse-on chip overrides it below.
      if (strobe_c) begin
         dac_i_d = '0;
         sub_d   = sub_end_c ? '0 : sub_q + SUB_W'(1);
         if (sub_end_c) begin
            chip_d = chip_q + CHIP_W'(1);
         end
      end

      case (state_q)
         ST_IDLE, ST_LOAD: begin
            sub_d  = sub_q;
            chip_d = chip_q;
            if (accept_c) begin
               if (word_cnt_q == 2'd3) begin
                  msg_d    = {msg_q[MSG_W-17:0], s_axis_data[31:16]};
                  crc_en_d = s_axis_data[0];
               end else begin
                  msg_d = {msg_q[MSG_W-33:0], s_axis_data[31:0]};
               end
               if (s_axis_last) begin
                  word_cnt_d = '0;
                  if (word_cnt_q == 2'd3) begin
                     state_d   = ST_WAIT_STROBE;
                     busy_d    = 1'b1;
                     chip_d    = '0;
                     sub_d     = '0;
                     crc_clr_c = 1'b1;
                  end else begin
                     state_d     = ST_IDLE;
                     frame_err_d = 1'b1;
                  end
               end else if (word_cnt_q == 2'd3) begin
                  state_d    = ST_DRAIN;
                  word_cnt_d = '0;
               end else begin
                  state_d    = ST_LOAD;
                  word_cnt_d = word_cnt_q + 2'd1;
               end
            end
         end

         ST_DRAIN: begin
            sub_d  = sub_q;
            chip_d = chip_q;
            if (accept_c && s_axis_last) begin
               state_d     = ST_IDLE;
               frame_err_d = 1'b1;
            end
         end

         // The strobe that leaves WAIT_STROBE already carries preamble chip 0.
         ST_WAIT_STROBE, ST_PREAMBLE: begin
            if (strobe_c) begin
               state_d   = ST_PREAMBLE;
               chip_on_c = adsb_preamble[pre_idx_c];
               if (sub_end_c && chip_q == CHIP_W'(adsb_preamble_chips - 1)) begin
                  state_d = ST_DATA;
                  chip_d  = '0;
               end
            end
         end

         ST_DATA: begin
            if (strobe_c) begin
               chip_on_c    = chip_q[0] ? ~msg_q[MSG_W-1] : msg_q[MSG_W-1];
               crc_bit_en_c = crc_en_q && !chip_q[0] && (sub_q == '0) &&
                              (chip_q < CHIP_W'(adsb_crc_data_chips));
               if (sub_end_c && chip_q[0]) begin
                  msg_d = {msg_q[MSG_W-2:0], 1'b0};
                  if (crc_en_q && chip_q == CHIP_W'(adsb_crc_data_chips - 1)) begin
                     msg_d[MSG_W-1 -: 24] = crc_rem;
                  end
               end
               if (sub_end_c && chip_q == CHIP_W'(adsb_data_chips - 1)) begin
                  state_d = ST_GAP;
                  chip_d  = '0;
               end
            end
         end

         // Tx_done is raised the cycle after the final gap strobe.
         ST_GAP: begin
            if (gap_done_q) begin
               gap_done_d = 1'b0;
               tx_done_d  = 1'b1;
               busy_d     = 1'b0;
               state_d    = ST_IDLE;
            end else if (strobe_c && sub_end_c && chip_q == CHIP_W'(GAP_CHIPS - 1)) begin
               gap_done_d = 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (strobe_c && chip_on_c) begin
         dac_i_d = IQ_WIDTH'(AMPLITUDE);
      end

      // Hold ready low for the Tx_done cycle so the next word follows it.
      ready_d = ((state_d == ST_IDLE) || (state_d == ST_LOAD) || (state_d == ST_DRAIN)) &&
                !tx_done_d;
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         word_cnt_q  <= '0;
         msg_q       <= '0;
         crc_en_q    <= 1'b0;
         chip_q      <= '0;
         sub_q       <= '0;
         gap_done_q  <= 1'b0;
         ready_q     <= 1'b1;
         dac_valid_q <= 1'b0;
         dac_i_q     <= '0;
         busy_q      <= 1'b0;
         tx_done_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         word_cnt_q  <= word_cnt_d;
         msg_q       <= msg_d;
         crc_en_q    <= crc_en_d;
         chip_q      <= chip_d;
         sub_q       <= sub_d;
         gap_done_q  <= gap_done_d;
         ready_q     <= ready_d;
         dac_valid_q <= dac_valid_d;
         dac_i_q     <= dac_i_d;
         busy_q      <= busy_d;
         tx_done_q   <= tx_done_d;
         frame_err_q <= frame_err_d;
      end
   end

   // Ready is forced low while reset is held so no word is offered to a resetting block.
   assign s_axis_ready = ready_q & resetn;
   assign dac_valid    = dac_valid_q;
   assign dac_data_i   = dac_i_q;
   assign dac_data_q   = '0;
   assign busy         = busy_q;
   assign tx_done      = tx_done_q;
   assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_adsb_modulator.sv
// Scoreboard bench for adsb_modulator: expected events queued at stimulus, checked by a monitor.
module tb_adsb_modulator;

   localparam int unsigned IQW   = 14;
   localparam int unsigned SDIV  = 4;
   localparam int unsigned SPC   = 2;
   localparam int unsigned GAPC  = 16;
   localparam int unsigned AMP   = 4096;
   localparam int          MSG_SAMPLES = 240 * SPC;
   localparam int          TOTAL       = MSG_SAMPLES + GAPC * SPC;
   localparam logic [23:0] POLY  = 24'hFFF409;

   logic                   clk = 1'b0;
   logic                   resetn = 1'b0;
   logic                   s_axis_valid = 1'b0;
   logic                   s_axis_ready;
   logic [31:0]            s_axis_data = '0;
   logic                   s_axis_last = 1'b0;
   logic                   dac_valid;
   logic signed [IQW-1:0]  dac_data_i;
   logic signed [IQW-1:0]  dac_data_q;
   logic                   busy;
   logic                   tx_done;
   logic                   frame_err;

   always #5 clk = ~clk;

   adsb_modulator #(
      .AXI_DATA_WIDTH   (32),
      .IQ_WIDTH         (IQW),
      .SAMPLE_DIV       (SDIV),
      .SAMPLES_PER_CHIP (SPC),
      .GAP_CHIPS        (GAPC),
      .AMPLITUDE        (AMP)
   ) dut (
      .clk          (clk),
      .resetn       (resetn),
      .s_axis_valid (s_axis_valid),
      .s_axis_ready (s_axis_ready),
      .s_axis_data  (s_axis_data),
      .s_axis_last  (s_axis_last),
      .dac_valid    (dac_valid),
      .dac_data_i   (dac_data_i),
      .dac_data_q   (dac_data_q),
      .busy         (busy),
      .tx_done      (tx_done),
      .frame_err    (frame_err)
   );

   typedef struct {
      bit           is_msg;
      logic [111:0] bits;
   } ev_t;

   ev_t          exp_q[$];
   int           sample_q[$];
   int           n_cmp = 0;
   int           n_fail = 0;
   int           idle_nz = 0;
   int           q_nz = 0;
   int           cyc = 0;
   int           txdone_cyc = -1000;
   int           n_txdone = 0;
   int           exp_txdone = 0;
   logic [111:0] dec_last = '0;

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk_vec(input string name, input logic [111:0] act, input logic [111:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Parity as the remainder of polynomial long division of the 88 data bits shifted by 24.
   function automatic logic [23:0] crc_model(input logic [111:0] m);
      logic [111:0] r;
      r = {m[111:24], 24'h000000};
      for (int i = 111; i >= 24; i--) begin
         if (r[i]) r[i -: 25] = r[i -: 25] ^ {1'b1, POLY};
      end
      return r[23:0];
   endfunction

   function automatic logic [111:0] tx_bits(input logic [111:0] m, input bit crc_en);
      return crc_en ? {m[111:24], crc_model(m)} : m;
   endfunction

   // Expected I value at sample idx of a transmission (preamble, PPM data, then gap).
   function automatic int exp_sample(input logic [111:0] b, input int idx);
      int chip;
      int k;
      bit on;
      chip = idx / SPC;
      if (chip < 16) begin
         on = (chip == 0) || (chip == 2) || (chip == 7) || (chip == 9);
      end else if (chip < 240) begin
         k  = (chip - 16) / 2;
         on = (((chip - 16) % 2) == 0) ? b[111 - k] : !b[111 - k];
      end else begin
         on = 1'b0;
      end
      return on ? int'(AMP) : 0;
   endfunction

   task automatic check_msg();
      ev_t          e;
      int           bad;
      int           first_bad;
      logic [111:0] dec;
      n_txdone++;
      txdone_cyc = cyc;
      chk("event_pending_at_tx_done", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("event_kind_tx_done", e.is_msg, 1);
         chk("sample_count", sample_q.size(), TOTAL);
         bad = 0;
         first_bad = -1;
         for (int i = 0; i < sample_q.size() && i < TOTAL; i++) begin
            if (sample_q[i] != exp_sample(e.bits, i)) begin
               if (first_bad < 0) first_bad = i;
               bad++;
            end
         end
         if (bad != 0)
            $display("first bad sample %0d: got %0d expected %0d", first_bad,
                     sample_q[first_bad], exp_sample(e.bits, first_bad));
         chk("waveform_bad_samples", bad, 0);
         dec = '0;
         if (sample_q.size() >= MSG_SAMPLES) begin
            for (int k = 0; k < 112; k++)
               dec[111 - k] = sample_q[(16 + 2 * k) * SPC] > sample_q[(17 + 2 * k) * SPC];
         end
         dec_last = dec;
         chk_vec("decoded_bits", dec, e.bits);
      end
      sample_q.delete();
   endtask

   task automatic check_ferr();
      ev_t e;
      chk("event_pending_at_frame_err", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("event_kind_frame_err", e.is_msg, 0);
      end
   endtask

   // Monitor: collect samples while busy, settle events against the scoreboard.
   always @(negedge clk) begin
      if (!resetn) begin
         sample_q.delete();
      end else begin
         if (dac_valid) begin
            if (busy) sample_q.push_back(int'(dac_data_i));
            else if (dac_data_i != 0) idle_nz++;
            if (dac_data_q != 0) q_nz++;
         end
         if (tx_done) check_msg();
         if (frame_err) check_ferr();
      end
   end

   task automatic send_word(input logic [31:0] d, input logic l, output int delta);
      int n;
      s_axis_valid = 1'b1;
      s_axis_data  = d;
      s_axis_last  = l;
      n = 0;
      while (!s_axis_ready && n < 6000) begin
         @(negedge clk);
         n++;
      end
      if (!s_axis_ready) chk("ready_wait", s_axis_ready, 1);
      delta = cyc - txdone_cyc;
      @(negedge clk);
   endtask

   task automatic send_msg(input logic [111:0] m, input bit crc_en, input bit keep,
                           output int first_delta);
      ev_t e;
      int  d;
      e.is_msg = 1'b1;
      e.bits   = tx_bits(m, crc_en);
      exp_q.push_back(e);
      exp_txdone++;
      send_word(m[111:80], 1'b0, first_delta);
      send_word(m[79:48], 1'b0, d);
      send_word(m[47:16], 1'b0, d);
      send_word({m[15:0], 15'h0000, crc_en}, 1'b1, d);
      if (!keep) begin
         s_axis_valid = 1'b0;
         s_axis_last  = 1'b0;
      end
   endtask

   task automatic expect_ferr();
      ev_t e;
      e.is_msg = 1'b0;
      e.bits   = '0;
      exp_q.push_back(e);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || busy) && n < 8000) begin
         @(negedge clk);
         n++;
      end
      chk("scoreboard_drained", exp_q.size(), 0);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      logic [111:0] known;
      logic [111:0] m;
      int           d;
      int           b2b_delta;
      int           tx_before;

      known = 112'h8D4840D6202CC371C32CE0576098;

      // Reset behaviour.
      repeat (3) @(negedge clk);
      chk("rst_ready_low", s_axis_ready, 0);
      chk("rst_dac_valid", dac_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_dac_i", dac_data_i, 0);
      resetn = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", s_axis_ready, 1);
      chk("post_rst_dac_valid", dac_valid, 0);
      chk("post_rst_busy", busy, 0);
      chk("post_rst_tx_done", tx_done, 0);
      chk("post_rst_frame_err", frame_err, 0);
      chk("post_rst_dac_i", dac_data_i, 0);

      // Known vector sent verbatim.
      send_msg(known, 1'b0, 1'b0, d);
      wait_idle();
      chk_vec("known_verbatim", dec_last, known);

      // Same vector with parity regenerated from the first 88 bits.
      send_msg({known[111:16], 16'h0000}, 1'b1, 1'b0, d);
      wait_idle();
      chk_vec("known_crc_regen", dec_last, known);

      // Short frame: last on word1, then a good message.
      expect_ferr();
      send_word(32'h8D4840D6, 1'b0, d);
      send_word(32'h202CC371, 1'b1, d);
      s_axis_valid = 1'b0;
      s_axis_last  = 1'b0;
      m = {$urandom(), $urandom(), $urandom(), 16'($urandom())};
      send_msg(m, 1'b0, 1'b0, d);
      wait_idle();

      // Long frame: five words, last on word4.
      expect_ferr();
      for (int i = 0; i < 5; i++) send_word($urandom(), (i == 4), d);
      s_axis_valid = 1'b0;
      s_axis_last  = 1'b0;
      repeat (4) @(negedge clk);
      chk("ready_after_drain", s_axis_ready, 1);
      wait_idle();

      // Back-to-back with valid held high.
      tx_before = n_txdone;
      m = {$urandom(), $urandom(), $urandom(), 16'($urandom())};
      send_msg(m, 1'($urandom()), 1'b1, d);
      m = {$urandom(), $urandom(), $urandom(), 16'($urandom())};
      send_msg(m, 1'($urandom()), 1'b0, b2b_delta);
      wait_idle();
      chk("b2b_accept_after_tx_done", b2b_delta, 1);
      chk("b2b_tx_done_count", n_txdone - tx_before, 2);

      // Reset during DATA of message 1, then resend message 2.
      m = {$urandom(), $urandom(), $urandom(), 16'($urandom())};
      send_msg(m, 1'b1, 1'b0, d);
      repeat (200) @(negedge clk);
      chk("busy_before_abort", busy, 1);
      void'(exp_q.pop_back());
      exp_txdone--;
      resetn = 1'b0;
      @(negedge clk);
      chk("abort_dac_i", dac_data_i, 0);
      chk("abort_busy", busy, 0);
      chk("abort_dac_valid", dac_valid, 0);
      resetn = 1'b1;
      @(negedge clk);
      chk("abort_ready", s_axis_ready, 1);
      m = {$urandom(), $urandom(), $urandom(), 16'($urandom())};
      send_msg(m, 1'b0, 1'b0, d);
      wait_idle();

      // Random messages, random parity mode and random valid holding.
      for (int i = 0; i < 4; i++) begin
         m = {$urandom(), $urandom(), $urandom(), 16'($urandom())};
         send_msg(m, 1'($urandom()), (i != 3) && 1'($urandom()), d);
      end
      wait_idle();

      chk("idle_nonzero_samples", idle_nz, 0);
      chk("q_nonzero_samples", q_nz, 0);
      chk("tx_done_total", n_txdone, exp_txdone);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
